// File: rtl/csi_frame_sched_if.sv
// Packet request bundle between the frame sequencer and the CSI-2
// packet/PHY engine. The sequencer is the master: it raises pkt_req with
// stable header fields, and the engine answers with pkt_ack once it has
// taken the request and pkt_done once the lane is back at LP-11.
interface csi_frame_sched_if;
  logic        pkt_req;
  logic        pkt_long;
  logic [7:0]  pkt_di;
  logic [15:0] pkt_wc;
  logic        pkt_ack;
  logic        pkt_done;

  modport master (
    output pkt_req,
    output pkt_long,
    output pkt_di,
    output pkt_wc,
    input  pkt_ack,
    input  pkt_done
  );

  modport slave (
    input  pkt_req,
    input  pkt_long,
    input  pkt_di,
    input  pkt_wc,
    output pkt_ack,
    output pkt_done
  );
endinterface

// File: rtl/csi_frame_sched.sv
// Frame-level sequencer for the 4-lane CSI-2 HS transmit path.
// Each accepted frame request produces FS, lnum line (long) packets and FE.
// Lines are gated on payload FIFO fill; every packet is followed by an
// LP-11 gap of GAP_CYC cycles. All packet outputs are registered, so a
// request appears one cycle after its *_REQ state is entered.
module csi_frame_sched #(
  parameter logic [1:0]  VC         = 2'd0,
  parameter logic [5:0]  DT_LINE    = 6'h2A,
  parameter logic [15:0] LINE_WC    = 16'd65535,
  parameter logic [7:0]  GAP_CYC    = 8'd32,
  parameter logic [14:0] LINE_WORDS = 15'd16384
) (
  input  logic                     coreclk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [15:0]              fno,
  input  logic [7:0]               lnum,
  input  logic [14:0]              fifo_level,
  input  logic                     phy_ready,
  csi_frame_sched_if.master        pkt,
  output logic                     busy,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               line_idx,
  output logic [7:0]               drop_cnt
);

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;

  typedef enum logic [3:0] {
    IDLE,
    FS_REQ,
    FS_WAIT,
    GAP,
    LN_CHK,
    LN_REQ,
    LN_WAIT,
    FE_REQ,
    FE_WAIT,
    END_GAP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  gap_cnt;
  logic [15:0] fno_q;
  logic [7:0]  lnum_q;

  logic        in_req;
  logic        acked;
  logic        start_ok;
  logic        dropped;
  logic        gap_last;
  logic        more_lines;
  logic        fifo_ok;
  logic        line_done;
  logic        frame_end;

  // An ack only counts while the request is actually visible to the engine;
  // an ack in the first cycle of a *_REQ state (before pkt_req rises) is stray.
  assign in_req     = (state == FS_REQ) || (state == LN_REQ) || (state == FE_REQ);
  assign acked      = in_req && pkt.pkt_req && pkt.pkt_ack;
  assign start_ok   = frame_start && phy_ready;
  assign dropped    = frame_start && ((state != IDLE) || !phy_ready);
  // Compare in 9 bits so GAP_CYC = 0 degenerates to a single-cycle gap.
  assign gap_last   = ({1'b0, gap_cnt} + 9'd1) >= {1'b0, GAP_CYC};
  assign more_lines = line_idx < lnum_q;
  assign fifo_ok    = fifo_level >= LINE_WORDS;

  // A line completes on pkt_done in LN_WAIT, or on an ack+done collision in LN_REQ.
  assign line_done  = ((state == LN_REQ) && acked && pkt.pkt_done) ||
                      ((state == LN_WAIT) && pkt.pkt_done);
  assign frame_end  = (state == END_GAP) && gap_last;

  // State register.
  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode. pkt_done outside a *_WAIT state is ignored unless it
  // arrives together with the ack, in which case the wait state is skipped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = FS_REQ;
      end
      FS_REQ: begin
        if (acked) state_nxt = pkt.pkt_done ? GAP : FS_WAIT;
      end
      FS_WAIT: begin
        if (pkt.pkt_done) state_nxt = GAP;
      end
      GAP: begin
        if (gap_last) state_nxt = more_lines ? LN_CHK : FE_REQ;
      end
      LN_CHK: begin
        if (fifo_ok) state_nxt = LN_REQ;
      end
      LN_REQ: begin
        if (acked) state_nxt = pkt.pkt_done ? GAP : LN_WAIT;
      end
      LN_WAIT: begin
        if (pkt.pkt_done) state_nxt = GAP;
      end
      FE_REQ: begin
        if (acked) state_nxt = pkt.pkt_done ? END_GAP : FE_WAIT;
      end
      FE_WAIT: begin
        if (pkt.pkt_done) state_nxt = END_GAP;
      end
      END_GAP: begin
        if (gap_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gap timer: runs only inside GAP/END_GAP and is zero on entry to either.
  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      gap_cnt <= 8'd0;
    end else if (((state == GAP) || (state == END_GAP)) && !gap_last) begin
      gap_cnt <= gap_cnt + 8'd1;
    end else begin
      gap_cnt <= 8'd0;
    end
  end

  // Frame parameters captured on an accepted frame_start; held for the frame.
  always_ff @(posedge coreclk) begin
    if ((state == IDLE) && start_ok) begin
      fno_q  <= fno;
      lnum_q <= lnum;
    end
  end

  // Registered packet outputs. The header fields are rewritten each cycle of
  // a *_REQ state from frame-constant values, so they cannot move before ack.
  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      pkt.pkt_req  <= 1'b0;
      pkt.pkt_long <= 1'b0;
      pkt.pkt_di   <= 8'h00;
      pkt.pkt_wc   <= 16'h0000;
    end else begin
      pkt.pkt_req <= in_req && !acked;
      case (state)
        FS_REQ: begin
          pkt.pkt_long <= 1'b0;
          pkt.pkt_di   <= {VC, DT_FS};
          pkt.pkt_wc   <= fno_q;
        end
        LN_REQ: begin
          pkt.pkt_long <= 1'b1;
          pkt.pkt_di   <= {VC, DT_LINE};
          pkt.pkt_wc   <= LINE_WC;
        end
        FE_REQ: begin
          pkt.pkt_long <= 1'b0;
          pkt.pkt_di   <= {VC, DT_FE};
          pkt.pkt_wc   <= fno_q;
        end
        default: ;
      endcase
    end
  end

  // Frame-in-progress flag and current line index.
  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      line_idx <= 8'd0;
    end else if ((state == IDLE) && start_ok) begin
      busy     <= 1'b1;
      line_idx <= 8'd0;
    end else begin
      if (frame_end) busy <= 1'b0;
      if (line_done) line_idx <= line_idx + 8'd1;
    end
  end

  // Status counters: completed frames wrap, rejected requests saturate.
  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      drop_cnt  <= 8'd0;
    end else begin
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
      if (dropped && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
